multimode_ring_counter: RTL and testbench

MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

---
 rtl/ring_counter_pkg.sv | 14 +
 rtl/ring_next_state.sv | 37 +++
 rtl/multimode_ring_counter.sv | 98 +++++++++
 tb/tb_multimode_ring_counter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared mode/direction encodings and seed helper for the ring counter
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_TO_MSB   = 1'b0;
    localparam logic DIR_TO_LSB   = 1'b1;

    // Seed is 32 bits wide; callers size-cast it to their own WIDTH.
    function automatic logic [31:0] ring_seed(input logic mode);
        return (mode == MODE_RING) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/ring_next_state.sv
// rtl/ring_next_state.sv - combinational step and legality check for ring/Johnson sequences
module ring_next_state
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             mode_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] next_o,
    output logic             is_legal_o
);

    logic [WIDTH-1:0] inv_count;
    logic             low_ones;
    logic             high_ones;

    assign inv_count = ~count_i;
    // x is 0..01..1 exactly when x & (x+1) is zero; the complement test covers 1..10..0.
    assign low_ones  = ((count_i & (count_i + 1'b1)) == '0);
    assign high_ones = ((inv_count & (inv_count + 1'b1)) == '0);

    always_comb begin
        next_o     = count_i;
        is_legal_o = 1'b0;
        if (mode_i == MODE_RING) begin
            is_legal_o = (count_i != '0) && ((count_i & (count_i - 1'b1)) == '0);
            if (dir_i == DIR_TO_MSB) next_o = {count_i[WIDTH-2:0], count_i[WIDTH-1]};
            else                     next_o = {count_i[0], count_i[WIDTH-1:1]};
        end else begin
            is_legal_o = low_ones || high_ones;
            if (dir_i == DIR_TO_MSB) next_o = {count_i[WIDTH-2:0], ~count_i[WIDTH-1]};
            else                     next_o = {~count_i[0], count_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/multimode_ring_counter.sv
// rtl/multimode_ring_counter.sv - ring/Johnson counter with load; RING_SELF_CORRECT_EN adds illegal-state recovery
module multimode_ring_counter
    import ring_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             state_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] seed_in, seed_q;
    logic [WIDTH-1:0] step_next;
    logic             step_legal;

    assign seed_in = WIDTH'(ring_seed(mode));
    assign seed_q  = WIDTH'(ring_seed(mode_q));

    ring_next_state #(.WIDTH(WIDTH)) u_next (
        .count_i    (count_q),
        .mode_i     (mode_q),
        .dir_i      (dir),
        .next_o     (step_next),
        .is_legal_o (step_legal)
    );

`ifdef RING_SELF_CORRECT_EN
    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (mode != mode_q) begin
            count_d = seed_in;
            mode_d  = mode;
        end else if (en) begin
            if (!step_legal) begin
                count_d = seed_q;
                err_d   = 1'b1;
            end else begin
                count_d = step_next;
                wrap_d  = (step_next == seed_q);
            end
        end
    end
`else
    logic unused_step_legal;
    assign unused_step_legal = step_legal;

    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (mode != mode_q) begin
            count_d = seed_in;
            mode_d  = mode;
        end else if (en) begin
            count_d = step_next;
            wrap_d  = (step_next == seed_q);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= seed_in;
            mode_q  <= mode;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign count     = count_q;
    assign wrap      = wrap_q;
    assign state_err = err_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// tb/tb_multimode_ring_counter.sv - scoreboard bench for multimode_ring_counter at WIDTH=4
module tb_multimode_ring_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       wrap;
    logic       state_err;

    int n_cmp;
    int n_mis;

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic       wrp;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    multimode_ring_counter #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .dir       (dir),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .wrap      (wrap),
        .state_err (state_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge state, then pop and compare.
    task automatic cyc(input string tag, input logic r, input logic ld, input logic [3:0] lv,
                       input logic e, input logic d, input logic m,
                       input logic [3:0] ec, input logic ew, input logic ee);
        exp_t x;
        @(negedge clk);
        reset = r; load = ld; load_val = lv; en = e; dir = d; mode = m;
        x.tag = tag; x.cnt = ec; x.wrp = ew; x.err = ee;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            x = exp_q.pop_front();
            check_eq({x.tag, "_count"}, 32'(count), 32'(x.cnt));
            check_eq({x.tag, "_wrap"}, 32'(wrap), 32'(x.wrp));
            check_eq({x.tag, "_err"}, 32'(state_err), 32'(x.err));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b0; load = 1'b0; load_val = 4'h0; en = 1'b0; dir = 1'b0; mode = 1'b0;

        // Ring reset and full rotation toward MSB
        cyc("rst_ring", 0, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
        cyc("r1",       1, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
        cyc("r2",       1, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
        cyc("r3",       1, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
        cyc("r4_wrap",  1, 0, 4'h0, 1, 0, 0, 4'b0001, 1, 0);
        cyc("r_hold",   1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);

        // Johnson reset and 8-step period toward MSB
        cyc("rst_john", 0, 0, 4'h0, 0, 0, 1, 4'b0000, 0, 0);
        cyc("j1",       1, 0, 4'h0, 1, 0, 1, 4'b0001, 0, 0);
        cyc("j2",       1, 0, 4'h0, 1, 0, 1, 4'b0011, 0, 0);
        cyc("j3",       1, 0, 4'h0, 1, 0, 1, 4'b0111, 0, 0);
        cyc("j4",       1, 0, 4'h0, 1, 0, 1, 4'b1111, 0, 0);
        cyc("j5",       1, 0, 4'h0, 1, 0, 1, 4'b1110, 0, 0);
        cyc("j6",       1, 0, 4'h0, 1, 0, 1, 4'b1100, 0, 0);
        cyc("j7",       1, 0, 4'h0, 1, 0, 1, 4'b1000, 0, 0);
        cyc("j8_wrap",  1, 0, 4'h0, 1, 0, 1, 4'b0000, 1, 0);

        // Johnson toward LSB
        cyc("jl1",      1, 0, 4'h0, 1, 1, 1, 4'b1000, 0, 0);
        cyc("jl2",      1, 0, 4'h0, 1, 1, 1, 4'b1100, 0, 0);
        cyc("jl3",      1, 0, 4'h0, 1, 1, 1, 4'b1110, 0, 0);
        cyc("jl4",      1, 0, 4'h0, 1, 1, 1, 4'b1111, 0, 0);
        cyc("jl5",      1, 0, 4'h0, 1, 1, 1, 4'b0111, 0, 0);
        cyc("jl6",      1, 0, 4'h0, 1, 1, 1, 4'b0011, 0, 0);
        cyc("jl7",      1, 0, 4'h0, 1, 1, 1, 4'b0001, 0, 0);
        cyc("jl8_wrap", 1, 0, 4'h0, 1, 1, 1, 4'b0000, 1, 0);

        // Ring direction change without bubble, then load over en
        cyc("rst_ring2", 0, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
        cyc("d1",        1, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
        cyc("d2",        1, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
        cyc("dir_flip",  1, 0, 4'h0, 1, 1, 0, 4'b0010, 0, 0);
        cyc("load_en",   1, 1, 4'b1000, 1, 1, 0, 4'b1000, 0, 0);
        cyc("rl1",       1, 0, 4'h0, 1, 1, 0, 4'b0100, 0, 0);
        cyc("rl2",       1, 0, 4'h0, 1, 1, 0, 4'b0010, 0, 0);
        cyc("rl3_wrap",  1, 0, 4'h0, 1, 1, 0, 4'b0001, 1, 0);
        cyc("load_seed", 1, 1, 4'b0001, 1, 0, 0, 4'b0001, 0, 0);

        // Johnson mid-sequence switched back to ring, then held
        cyc("to_john",   1, 0, 4'h0, 1, 0, 1, 4'b0000, 0, 0);
        cyc("m1",        1, 0, 4'h0, 1, 0, 1, 4'b0001, 0, 0);
        cyc("m2",        1, 0, 4'h0, 1, 0, 1, 4'b0011, 0, 0);
        cyc("m3",        1, 0, 4'h0, 1, 0, 1, 4'b0111, 0, 0);
        cyc("to_ring",   1, 0, 4'h0, 1, 0, 0, 4'b0001, 0, 0);
        cyc("hold1",     1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
        cyc("hold2",     1, 0, 4'h0, 0, 1, 0, 4'b0001, 0, 0);
        cyc("hold3",     1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);

        // Load wins over a pending mode change; the change lands the next cycle
        cyc("load_vs_mode", 1, 1, 4'b0101, 1, 0, 1, 4'b0101, 0, 0);
        cyc("mode_after",   1, 0, 4'h0,    0, 0, 1, 4'b0000, 0, 0);
        cyc("back_ring",    1, 0, 4'h0,    0, 0, 0, 4'b0001, 0, 0);

        // Illegal ring state stepped
        cyc("load_bad",  1, 1, 4'b0110, 0, 0, 0, 4'b0110, 0, 0);
`ifdef RING_SELF_CORRECT_EN
        cyc("bad_step",  1, 0, 4'h0, 1, 0, 0, 4'b0001, 0, 1);
        cyc("bad_after", 1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
`else
        cyc("bad_step",  1, 0, 4'h0, 1, 0, 0, 4'b1100, 0, 0);
        cyc("bad_after", 1, 0, 4'h0, 0, 0, 0, 4'b1100, 0, 0);
`endif

        // Reset beats load and en mid-sequence
        cyc("load_1000",  1, 1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0);
        cyc("rst_over",   0, 1, 4'b0100, 1, 0, 0, 4'b0001, 0, 0);
        cyc("post_rst",   1, 0, 4'h0,    1, 0, 0, 4'b0010, 0, 0);
        cyc("rst_mode",   0, 1, 4'b1010, 1, 0, 1, 4'b0000, 0, 0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
